// File: rtl/jtdd_mcu_pkg.sv
// Shared definitions for the Double Dragon main-CPU <-> MCU link.
package jtdd_mcu_pkg;

  // Default geometry: 512-byte shared RAM, 64 MCU ticks before a forced halt
  localparam int AW_DEF      = 9;
  localparam int HALT_TO_DEF = 64;

  // Halt handshake state encoding
  typedef logic [1:0] halt_st_t;
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Value the main CPU sees when it reads the RAM without owning it
  localparam logic [7:0] IDLE_RD = 8'hFF;

  // Width of a counter that has to reach n-1
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jtdd_mcu_halt.sv
// Halt / bus-available handshake between the main CPU and the MCU.
// The MCU is asked to halt; it is considered halted once it raises BA on a
// cen tick, or after HALT_TO ticks without BA, so a stuck MCU never locks
// the main CPU out of the shared RAM.
module jtdd_mcu_halt
  import jtdd_mcu_pkg::*;
#(
  parameter int HALT_TO = HALT_TO_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic mcu_cen,
  input  logic mcu_halt,
  input  logic mcu_ba,
  output logic mcu_halt_o,
  output logic mcu_ban,
  output logic halted
);

  localparam int              CW       = cnt_w(HALT_TO);
  localparam logic [CW-1:0]   CNT_LAST = CW'(HALT_TO - 1);

  halt_st_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          halt_o_q, ban_q, halted_q;

  // Next-state and timeout counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        cnt_d = '0;
        if (mcu_halt) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!mcu_halt) begin
          // request withdrawn before the MCU granted the bus
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (mcu_cen) begin
          if (mcu_ba || cnt_q == CNT_LAST) begin
            state_d = ST_HALTED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_HALTED: begin
        cnt_d = '0;
        if (!mcu_halt) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered handshake outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      halt_o_q <= 1'b0;
      ban_q    <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halt_o_q <= (state_d != ST_RUN);
      ban_q    <= (state_d != ST_HALTED);
      halted_q <= (state_d == ST_HALTED);
    end
  end

  assign mcu_halt_o = halt_o_q;
  assign mcu_ban    = ban_q;
  assign halted     = halted_q;

endmodule

// File: rtl/jtdd_mcu_if.sv
// MCU-side end of the Double Dragon main-CPU <-> MCU link: shared RAM,
// halt handshake, NMI latch towards the MCU and IRQ pulse towards the main CPU.
// RAM ownership follows the halted flag: main CPU while halted, MCU otherwise,
// so the two write ports never collide and share a single physical port.
module jtdd_mcu_if
  import jtdd_mcu_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int HALT_TO = HALT_TO_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          mcu_cen,
  input  logic          main_cen,
  // main CPU side
  input  logic          com_cs,
  input  logic [AW-1:0] main_AB,
  input  logic          main_rnw,
  input  logic [7:0]    main_dout,
  output logic [7:0]    mcu_ram,
  input  logic          mcu_halt,
  output logic          mcu_ban,
  input  logic          mcu_nmi_set,
  output logic          mcu_irqmain,
  // MCU side
  output logic          mcu_halt_o,
  input  logic          mcu_ba,
  output logic          mcu_nmi,
  input  logic          mcu_nmi_ack,
  input  logic          mcu_irq_set,
  input  logic          mcu_ram_cs,
  input  logic [AW-1:0] mcu_AB,
  input  logic          mcu_wr,
  input  logic [7:0]    mcu_dout,
  output logic [7:0]    mcu_din
);

  logic halted;

  jtdd_mcu_halt #(
    .HALT_TO    (HALT_TO)
  ) u_halt (
    .clk        (clk),
    .rstn       (rstn),
    .mcu_cen    (mcu_cen),
    .mcu_halt   (mcu_halt),
    .mcu_ba     (mcu_ba),
    .mcu_halt_o (mcu_halt_o),
    .mcu_ban    (mcu_ban),
    .halted     (halted)
  );

  // ---------------- shared RAM ----------------
  logic [7:0]    ram_mem [0:(2**AW)-1];
  logic          main_we, mcu_we, ram_we;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [7:0]    mcu_ram_q, mcu_din_q;

  assign main_we = main_cen & com_cs & ~main_rnw & halted;
  assign mcu_we  = mcu_cen & mcu_ram_cs & mcu_wr & ~halted;
  assign ram_we  = main_we | mcu_we;
  assign wr_addr = halted ? main_AB   : mcu_AB;
  assign wr_data = halted ? main_dout : mcu_dout;

  // Single write port; the owner is selected by the halted flag
  always_ff @(posedge clk) begin
    if (ram_we) ram_mem[wr_addr] <= wr_data;
  end

  // Registered read ports: main sees idle data unless it owns the RAM,
  // MCU keeps its last read value while it is halted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mcu_ram_q <= IDLE_RD;
      mcu_din_q <= IDLE_RD;
    end else begin
      mcu_ram_q <= halted ? ram_mem[main_AB] : IDLE_RD;
      if (!halted) mcu_din_q <= ram_mem[mcu_AB];
    end
  end

  assign mcu_ram = mcu_ram_q;
  assign mcu_din = mcu_din_q;

  // ---------------- NMI latch and IRQ pulse ----------------
  logic nmi_set_q, nmi_q, irq_set_q, irqmain_q;
  logic nmi_edge, irq_edge;

  assign nmi_edge = mcu_nmi_set & ~nmi_set_q;
  assign irq_edge = mcu_irq_set & ~irq_set_q;

  // NMI is set by a request edge and held until the MCU acknowledges it;
  // a new edge in the same cycle as an ack keeps it set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nmi_set_q <= 1'b0;
      nmi_q     <= 1'b0;
    end else begin
      nmi_set_q <= mcu_nmi_set;
      if (nmi_edge)         nmi_q <= 1'b1;
      else if (mcu_nmi_ack) nmi_q <= 1'b0;
    end
  end

  // One-clock IRQ pulse towards the main CPU per rising edge of the port write
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_set_q <= 1'b0;
      irqmain_q <= 1'b0;
    end else begin
      irq_set_q <= mcu_irq_set;
      irqmain_q <= irq_edge;
    end
  end

  assign mcu_nmi     = nmi_q;
  assign mcu_irqmain = irqmain_q;

endmodule

// File: tb/tb_jtdd_mcu_if.sv
// Scoreboard bench for jtdd_mcu_if: the stimulus process pushes expected
// output values, a monitor pops and compares them on the falling edge.
module tb_jtdd_mcu_if;

  localparam int AW = 9;

  localparam int SIG_HALT = 0;
  localparam int SIG_BAN  = 1;
  localparam int SIG_NMI  = 2;
  localparam int SIG_IRQ  = 3;
  localparam int SIG_RAM  = 4;
  localparam int SIG_DIN  = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          mcu_cen, main_cen, com_cs, main_rnw;
  logic [AW-1:0] main_AB, mcu_AB;
  logic [7:0]    main_dout, mcu_dout;
  logic [7:0]    mcu_ram, mcu_din;
  logic          mcu_halt, mcu_ban, mcu_nmi_set, mcu_irqmain;
  logic          mcu_halt_o, mcu_ba, mcu_nmi, mcu_nmi_ack, mcu_irq_set;
  logic          mcu_ram_cs, mcu_wr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    string      name;
    int         sig;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  jtdd_mcu_if #(.AW(AW), .HALT_TO(64)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .mcu_cen     (mcu_cen),
    .main_cen    (main_cen),
    .com_cs      (com_cs),
    .main_AB     (main_AB),
    .main_rnw    (main_rnw),
    .main_dout   (main_dout),
    .mcu_ram     (mcu_ram),
    .mcu_halt    (mcu_halt),
    .mcu_ban     (mcu_ban),
    .mcu_nmi_set (mcu_nmi_set),
    .mcu_irqmain (mcu_irqmain),
    .mcu_halt_o  (mcu_halt_o),
    .mcu_ba      (mcu_ba),
    .mcu_nmi     (mcu_nmi),
    .mcu_nmi_ack (mcu_nmi_ack),
    .mcu_irq_set (mcu_irq_set),
    .mcu_ram_cs  (mcu_ram_cs),
    .mcu_AB      (mcu_AB),
    .mcu_wr      (mcu_wr),
    .mcu_dout    (mcu_dout),
    .mcu_din     (mcu_din)
  );

  function automatic logic [7:0] actual(input int sig);
    case (sig)
      SIG_HALT: return {7'd0, mcu_halt_o};
      SIG_BAN:  return {7'd0, mcu_ban};
      SIG_NMI:  return {7'd0, mcu_nmi};
      SIG_IRQ:  return {7'd0, mcu_irqmain};
      SIG_RAM:  return mcu_ram;
      default:  return mcu_din;
    endcase
  endfunction

  task automatic expect_sig(input string nm, input int sig, input logic [7:0] v);
    exp_t e;
    e.name = nm;
    e.sig  = sig;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: drain the scoreboard on every falling edge
  initial begin
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        exp_t       e;
        logic [7:0] a;
        e = sb_q.pop_front();
        a = actual(e.sig);
        total_cnt++;
        if (a === e.exp) begin
          pass_cnt++;
          $display("check %-14s got %02h exp %02h ok", e.name, a, e.exp);
        end else begin
          $display("FAIL %s: got %02h required %02h", e.name, a, e.exp);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; mcu_cen = 1'b0; main_cen = 1'b1; com_cs = 1'b0; main_rnw = 1'b1;
    main_AB = '0; mcu_AB = '0; main_dout = 8'h00; mcu_dout = 8'h00;
    mcu_halt = 1'b0; mcu_nmi_set = 1'b0; mcu_ba = 1'b0; mcu_nmi_ack = 1'b0;
    mcu_irq_set = 1'b0; mcu_ram_cs = 1'b0; mcu_wr = 1'b0;

    // ---- reset state ----
    tick();
    expect_sig("rst_halt_o", SIG_HALT, 8'h00);
    expect_sig("rst_ban",    SIG_BAN,  8'h01);
    expect_sig("rst_nmi",    SIG_NMI,  8'h00);
    expect_sig("rst_irq",    SIG_IRQ,  8'h00);
    expect_sig("rst_ram",    SIG_RAM,  8'hFF);
    expect_sig("rst_din",    SIG_DIN,  8'hFF);
    tick();
    rstn = 1'b1;
    tick();

    // ---- halt with grant on the 3rd mcu_cen ----
    mcu_halt = 1'b1;
    tick();
    expect_sig("req_halt_o", SIG_HALT, 8'h01);
    expect_sig("req_ban",    SIG_BAN,  8'h01);
    for (int i = 1; i <= 3; i++) begin
      mcu_cen = 1'b1;
      mcu_ba  = (i == 3);
      tick();
      mcu_cen = 1'b0;
      mcu_ba  = 1'b0;
      expect_sig(i == 3 ? "grant_ban" : "pregrant_ban", SIG_BAN, i == 3 ? 8'h00 : 8'h01);
      tick();
    end
    mcu_halt = 1'b0;
    tick();
    expect_sig("rel_ban",    SIG_BAN,  8'h01);
    expect_sig("rel_halt_o", SIG_HALT, 8'h00);

    // ---- MCU writes 5A at 010 in RUN; main write/read in RUN ignored ----
    mcu_AB = 9'h010; mcu_dout = 8'h5A; mcu_ram_cs = 1'b1; mcu_wr = 1'b1; mcu_cen = 1'b1;
    tick();
    mcu_ram_cs = 1'b0; mcu_wr = 1'b0; mcu_cen = 1'b0;
    com_cs = 1'b1; main_rnw = 1'b0; main_AB = 9'h010; main_dout = 8'h77;
    tick();
    main_rnw = 1'b1;
    tick();
    expect_sig("run_main_rd", SIG_RAM, 8'hFF);
    com_cs = 1'b0;
    expect_sig("run_mcu_rd",  SIG_DIN, 8'h5A);
    tick();

    // ---- halt by timeout: BA never rises ----
    mcu_halt = 1'b1;
    tick();
    for (int i = 1; i <= 64; i++) begin
      mcu_cen = 1'b1;
      tick();
      if (i == 63) expect_sig("to_63_ban", SIG_BAN, 8'h01);
      if (i == 64) expect_sig("to_64_ban", SIG_BAN, 8'h00);
    end
    mcu_cen = 1'b0;
    tick();

    // ---- main side accesses while halted ----
    com_cs = 1'b1; main_rnw = 1'b1; main_AB = 9'h010; mcu_AB = 9'h1FF;
    tick();
    expect_sig("hlt_main_rd", SIG_RAM, 8'h5A);
    main_rnw = 1'b0; main_AB = 9'h1FF; main_dout = 8'hC3;
    tick();
    main_rnw = 1'b1;
    tick();
    expect_sig("hlt_main_wr", SIG_RAM, 8'hC3);
    expect_sig("hlt_din_hold", SIG_DIN, 8'h5A);
    com_cs = 1'b0; mcu_halt = 1'b0;
    tick();
    expect_sig("rel2_ban", SIG_BAN, 8'h01);
    tick();
    expect_sig("rel2_din", SIG_DIN, 8'hC3);
    expect_sig("rel2_ram", SIG_RAM, 8'hFF);

    // ---- NMI ----
    mcu_nmi_set = 1'b1;
    tick();
    expect_sig("nmi_set", SIG_NMI, 8'h01);
    for (int i = 0; i < 4; i++) tick();
    expect_sig("nmi_held", SIG_NMI, 8'h01);
    mcu_nmi_set = 1'b0;
    tick();
    expect_sig("nmi_no_ack", SIG_NMI, 8'h01);
    mcu_nmi_set = 1'b1; mcu_nmi_ack = 1'b1;
    tick();
    expect_sig("nmi_set_wins", SIG_NMI, 8'h01);
    mcu_nmi_set = 1'b0;
    tick();
    expect_sig("nmi_ack", SIG_NMI, 8'h00);
    mcu_nmi_ack = 1'b0;
    tick();

    // ---- IRQ: held level gives one pulse ----
    mcu_irq_set = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_sig(i == 0 ? "irq_pulse" : "irq_held", SIG_IRQ, i == 0 ? 8'h01 : 8'h00);
    end
    mcu_irq_set = 1'b0;
    tick();
    // ---- two edges three clocks apart ----
    for (int i = 0; i < 5; i++) begin
      mcu_irq_set = (i == 0 || i == 3);
      tick();
      expect_sig((i == 0 || i == 3) ? "irq2_pulse" : "irq2_gap", SIG_IRQ,
                 (i == 0 || i == 3) ? 8'h01 : 8'h00);
    end
    mcu_irq_set = 1'b0;
    tick();

    // ---- async reset while halted with NMI pending ----
    mcu_nmi_set = 1'b1;
    mcu_halt    = 1'b1;
    tick();
    mcu_cen = 1'b1; mcu_ba = 1'b1;
    tick();
    mcu_cen = 1'b0; mcu_ba = 1'b0;
    expect_sig("pre_rst_ban", SIG_BAN, 8'h00);
    expect_sig("pre_rst_nmi", SIG_NMI, 8'h01);
    tick();
    rstn = 1'b0;
    expect_sig("arst_ban",    SIG_BAN,  8'h01);
    expect_sig("arst_halt_o", SIG_HALT, 8'h00);
    expect_sig("arst_nmi",    SIG_NMI,  8'h00);
    tick();
    mcu_halt = 1'b0; mcu_nmi_set = 1'b0;
    tick();
    rstn = 1'b1;
    mcu_AB = 9'h010;
    tick();
    expect_sig("post_rst_010", SIG_DIN, 8'h5A);
    mcu_AB = 9'h1FF;
    tick();
    expect_sig("post_rst_1FF", SIG_DIN, 8'hC3);
    tick();
    tick();

    if (sb_q.size() != 0) begin
      $display("FAIL scoreboard: %0d expectations left unchecked, required 0", sb_q.size());
      total_cnt += sb_q.size();
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
